mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 146 ++++++++++++++
 tb/tb_mem_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter in front of a single-ported data memory.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is data-port priority.
module mem_arb #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_whb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_din,
    output logic [1:0]        m_whb,
    input  logic [31:0]       m_dout
);

    localparam logic [1:0] WHB_SW = 2'b00;
    localparam logic [1:0] WHB_SH = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic              pick_d;
    logic              d_mis;
    logic              gnt_d;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [1:0]        whb_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    function automatic logic misaligned(input logic we, input logic [1:0] whb,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (we) begin
            if (whb == WHB_SW && lo != 2'b00) bad = 1'b1;
            if (whb == WHB_SH && lo[0])       bad = 1'b1;
        end
        return bad;
    endfunction

`ifdef ARB_RR_EN
    logic last_d;

    // On a tie the port that was not granted last wins.
    always_comb begin
        pick_d = d_req && (!i_req || !last_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_d <= 1'b1;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_d <= pick_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_comb begin
        d_mis = misaligned(d_we, d_whb, d_addr[1:0]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = (pick_d && d_mis) ? DONE : ACCESS;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_d     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            whb_q     <= WHB_SW;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state == IDLE && (i_req || d_req)) begin
                gnt_d  <= pick_d;
                addr_q <= pick_d ? d_addr : i_addr;
                we_q   <= pick_d && d_we;
                whb_q  <= pick_d ? d_whb : WHB_SW;
                err_q  <= pick_d && d_mis;
                if (pick_d) din_q <= d_wdata;
            end
            // Only reads refresh the port's read-data register.
            if (state == ACCESS && !we_q) begin
                if (gnt_d) d_rdata_q <= m_dout;
                else       i_rdata_q <= m_dout;
            end
        end
    end

    // Combinational from state so reset drops m_we without waiting for a clock.
    always_comb begin
        m_we    = (state == ACCESS) && we_q;
        i_ack   = (state == DONE) && !gnt_d;
        d_ack   = (state == DONE) && gnt_d;
        d_err   = (state == DONE) && gnt_d && err_q;
        m_addr  = addr_q;
        m_din   = din_q;
        m_whb   = whb_q;
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of single transactions plus contention and reset corner cases.
module tb_mem_arb;

    localparam int AW = 9;
    localparam logic [1:0] SW = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SB = 2'b10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_whb;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ack;
    logic          d_err;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_din;
    logic [1:0]    m_whb;
    logic [31:0]   m_dout;

    logic [31:0] mem [0:127];
    int checks = 0;
    int failures = 0;

    mem_arb #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_whb(d_whb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_whb(m_whb),
        .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Byte-lane little-endian memory with combinational read.
    assign m_dout = mem[m_addr[AW-1:2]];
    always @(posedge clk) begin
        if (m_we) begin
            case (m_whb)
                SW: mem[m_addr[AW-1:2]] <= m_din;
                SH: if (m_addr[1]) mem[m_addr[AW-1:2]][31:16] <= m_din[15:0];
                    else           mem[m_addr[AW-1:2]][15:0]  <= m_din[15:0];
                default: mem[m_addr[AW-1:2]][m_addr[1:0]*8 +: 8] <= m_din[7:0];
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
        chk({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
        chk({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
        chk({tag, "_m_we"}, {31'd0, m_we}, 32'd0);
        chk({tag, "_m_addr"}, {23'd0, m_addr}, 32'd0);
        chk({tag, "_m_din"}, m_din, 32'd0);
        chk({tag, "_m_whb"}, {30'd0, m_whb}, {30'd0, SW});
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        port_d;
        logic        we;
        logic [1:0]  whb;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic        exp_err;
        int          exp_mwe;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_txn(input vec_t v);
        int cyc = 0;
        int mwe = 0;
        int bad_flags = 0;
        logic got = 1'b0;
        logic ack_d = 1'b0;
        logic err = 1'b0;
        logic [AW-1:0] acc_addr = '0;
        logic [1:0] acc_whb = '0;
        i_req = !v.port_d; i_addr = v.addr;
        d_req = v.port_d; d_addr = v.addr; d_we = v.we; d_whb = v.whb; d_wdata = v.wdata;
        while (cyc < 10 && !got) begin
            @(negedge clk);
            cyc++;
            if (m_we) mwe++;
            if (cyc == 1) begin
                acc_addr = m_addr;
                acc_whb = m_whb;
            end
            if ((i_ack && d_ack) || (!d_ack && d_err)) bad_flags++;
            if (i_ack || d_ack) begin
                got = 1'b1;
                ack_d = d_ack;
                err = d_err;
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk({v.name, "_acked"}, {31'd0, got}, 32'd1);
        chk({v.name, "_port"}, {31'd0, ack_d}, {31'd0, v.port_d});
        chk({v.name, "_latency"}, cyc, v.exp_lat);
        chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        chk({v.name, "_mwe_cycles"}, mwe, v.exp_mwe);
        chk({v.name, "_flags"}, bad_flags, 0);
        chk({v.name, "_rdata"}, v.port_d ? d_rdata : i_rdata, v.exp_rdata);
        if (v.exp_lat == 2) begin
            chk({v.name, "_m_addr"}, {23'd0, acc_addr}, {23'd0, v.addr});
            chk({v.name, "_m_whb"}, {30'd0, acc_whb}, {30'd0, v.port_d ? v.whb : SW});
        end
        @(negedge clk);
    endtask

    vec_t vecs[13];
    logic [2:0] order;
    logic [2:0] exp_order;
    int nack;

    initial begin
        vecs[0]  = '{"fetch10",   1'b0, 1'b0, SW, 9'h010, 32'h0, 2, 1'b0, 0, 32'h8C010004};
        vecs[1]  = '{"ld20",      1'b1, 1'b0, SW, 9'h020, 32'h0, 2, 1'b0, 0, 32'h11223344};
        vecs[2]  = '{"sb21",      1'b1, 1'b1, SB, 9'h021, 32'h000000AB, 2, 1'b0, 1, 32'h11223344};
        vecs[3]  = '{"ld20b",     1'b1, 1'b0, SW, 9'h020, 32'h0, 2, 1'b0, 0, 32'h1122AB44};
        vecs[4]  = '{"sw06_mis",  1'b1, 1'b1, SW, 9'h006, 32'hFFFFFFFF, 1, 1'b1, 0, 32'h1122AB44};
        vecs[5]  = '{"ld04",      1'b1, 1'b0, SW, 9'h004, 32'h0, 2, 1'b0, 0, 32'hDEADBEEF};
        vecs[6]  = '{"sh31_mis",  1'b1, 1'b1, SH, 9'h031, 32'h00001234, 1, 1'b1, 0, 32'hDEADBEEF};
        vecs[7]  = '{"sh32",      1'b1, 1'b1, SH, 9'h032, 32'h00005566, 2, 1'b0, 1, 32'hDEADBEEF};
        vecs[8]  = '{"ld30",      1'b1, 1'b0, SW, 9'h030, 32'h0, 2, 1'b0, 0, 32'h55660000};
        vecs[9]  = '{"sw30",      1'b1, 1'b1, SW, 9'h030, 32'hCAFEF00D, 2, 1'b0, 1, 32'h55660000};
        vecs[10] = '{"ld33",      1'b1, 1'b0, SB, 9'h033, 32'h0, 2, 1'b0, 0, 32'hCAFEF00D};
        vecs[11] = '{"sb07",      1'b1, 1'b1, SB, 9'h007, 32'h000000EE, 2, 1'b0, 1, 32'hCAFEF00D};
        vecs[12] = '{"ld04b",     1'b1, 1'b0, SW, 9'h004, 32'h0, 2, 1'b0, 0, 32'hEEADBEEF};

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[9'h010 >> 2] = 32'h8C010004;
        mem[9'h020 >> 2] = 32'h11223344;
        mem[9'h004 >> 2] = 32'hDEADBEEF;

        // Contention setup: both requests held from reset.
        rstn = 1'b0;
        i_req = 1'b1; i_addr = 9'h010;
        d_req = 1'b1; d_addr = 9'h020; d_we = 1'b0; d_whb = SW; d_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;
        nack = 0;
        order = 3'b000;
        for (int c = 0; c < 20 && nack < 3; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) chk("contend_both_ack", 32'd1, 32'd0);
            if (i_ack || d_ack) begin
                order[nack] = d_ack;
                nack++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("contend_acks", nack, 3);
`ifdef ARB_RR_EN
        exp_order = 3'b010;
`else
        exp_order = 3'b111;
`endif
        chk("contend_grant0", {31'd0, order[0]}, {31'd0, exp_order[0]});
        chk("contend_grant1", {31'd0, order[1]}, {31'd0, exp_order[1]});
        chk("contend_grant2", {31'd0, order[2]}, {31'd0, exp_order[2]});
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(vecs[i]);
        chk("mem20_final", mem[9'h020 >> 2], 32'h1122AB44);
        chk("mem30_final", mem[9'h030 >> 2], 32'hCAFEF00D);

        // Reset in the middle of a store's ACCESS cycle.
        d_req = 1'b1; d_we = 1'b1; d_whb = SW; d_addr = 9'h030; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("abort_mwe_before", {31'd0, m_we}, 32'd1);
        #1 rstn = 1'b0;
        #1 chk("abort_mwe_immediate", {31'd0, m_we}, 32'd0);
        nack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) nack++;
        end
        d_req = 1'b0; d_we = 1'b0;
        chk("abort_no_ack", nack, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        chk("abort_mem_kept", mem[9'h030 >> 2], 32'hCAFEF00D);
        run_txn(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
